// File: rtl/mesh_router_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mesh_router_pkg
// Purpose : Shared constants and types for the 2D-mesh XY router.
//           Port indices, output direction encoding and arbiter lock state.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package mesh_router_pkg;

    localparam int P_L    = 0;
    localparam int P_N    = 1;
    localparam int P_E    = 2;
    localparam int P_S    = 3;
    localparam int P_W    = 4;
    localparam int NPORTS = 5;

    // Output direction; encoding matches the port index constants above.
    typedef enum logic [2:0] {
        DIR_L = 3'd0,
        DIR_N = 3'd1,
        DIR_E = 3'd2,
        DIR_S = 3'd3,
        DIR_W = 3'd4
    } dir_t;

    // Per-output arbiter state: free to grant, or held by one input
    // until that input's tail flit has been forwarded.
    typedef enum logic [0:0] {
        ARB_UNLOCKED = 1'b0,
        ARB_LOCKED   = 1'b1
    } arb_state_t;

    // The flit entry {data, last, dest} depends on module parameters, so the
    // concrete flit_entry_t struct is declared inside mesh_xy_router using
    // FLIT_WIDTH and XW+YW; this helper gives its packed width.
    function automatic int flit_entry_width(input int flit_w, input int dest_w);
        return flit_w + 1 + dest_w;
    endfunction

endpackage : mesh_router_pkg
`default_nettype wire

// File: rtl/mesh_xy_router_in_fifo.sv
`default_nettype none
// ============================================================================
// Module  : router_in_fifo
// Purpose : Synchronous input FIFO with full/empty flags, one per router port.
// Ports   : clk, rst      - clock, asynchronous active-high reset
//           push_i/data_i - write strobe and entry (ignored while full)
//           pop_i/data_o  - read strobe and head entry (ignored while empty)
//           full_o/empty_o- status flags
// Revision: 1.0 - initial release
// ============================================================================
module router_in_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: contents are only observed when count_q > 0.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule : router_in_fifo
`default_nettype wire

// File: rtl/mesh_xy_router.sv
`default_nettype none
// ============================================================================
// Module  : mesh_xy_router
// Purpose : Five-port (L,N,E,S,W) 2D-mesh router, XY dimension-ordered
//           routing, wormhole switching. Input FIFOs, per-output round-robin
//           arbiter with packet lock, registered valid/ready output stage.
// Ports   : clk, rst                          - clock, async active-high reset
//           in_valid/in_ready/in_data/in_last/in_dest  - 5 input channels
//           out_valid/out_ready/out_data/out_last/out_dest - 5 output channels
//           stat_flits                        - per-output forwarded-flit count
// Config  : MESH_ROUTER_STATS_EN - when defined, stat_flits counts output
//           handshakes (wrapping at 2^32); otherwise stat_flits is tied to 0.
// Revision: 1.0 - initial release
// ============================================================================
module mesh_xy_router
    import mesh_router_pkg::*;
#(
    parameter int FLIT_WIDTH = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int XW         = 2,
    parameter int YW         = 2,
    parameter int MY_X       = 0,
    parameter int MY_Y       = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NPORTS-1:0]               in_valid,
    output logic [NPORTS-1:0]               in_ready,
    input  logic [NPORTS*FLIT_WIDTH-1:0]    in_data,
    input  logic [NPORTS-1:0]               in_last,
    input  logic [NPORTS*(XW+YW)-1:0]       in_dest,
    output logic [NPORTS-1:0]               out_valid,
    input  logic [NPORTS-1:0]               out_ready,
    output logic [NPORTS*FLIT_WIDTH-1:0]    out_data,
    output logic [NPORTS-1:0]               out_last,
    output logic [NPORTS*(XW+YW)-1:0]       out_dest,
    output logic [NPORTS*32-1:0]            stat_flits
);
    localparam int            DW    = XW + YW;
    localparam int            EW    = flit_entry_width(FLIT_WIDTH, DW);
    localparam logic [XW-1:0] MY_XC = XW'(MY_X);
    localparam logic [YW-1:0] MY_YC = YW'(MY_Y);

    typedef struct packed {
        logic [FLIT_WIDTH-1:0] data;
        logic                  last;
        logic [DW-1:0]         dest;
    } flit_entry_t;

    flit_entry_t       head_w [NPORTS];
    logic [NPORTS-1:0] fifo_full, fifo_empty, fifo_push, fifo_pop;

    dir_t              route_cur [NPORTS];
    dir_t              route_q   [NPORTS];
    logic [NPORTS-1:0] route_vld_q;      // set while a packet body is in flight

    logic [NPORTS-1:0] req_m     [NPORTS];   // [output][input]
    logic [NPORTS-1:0] gnt_vld, xfer;
    logic [2:0]        gnt_idx   [NPORTS];
    arb_state_t        lock_q    [NPORTS];
    arb_state_t        lock_d    [NPORTS];
    logic [2:0]        owner_q   [NPORTS];
    logic [2:0]        owner_d   [NPORTS];
    logic [2:0]        rr_q      [NPORTS];
    logic [2:0]        rr_d      [NPORTS];
    int                idx;

    logic [NPORTS-1:0]     out_valid_q;
    logic [FLIT_WIDTH-1:0] out_data_q [NPORTS];
    logic                  out_last_q [NPORTS];
    logic [DW-1:0]         out_dest_q [NPORTS];

    // No bypass: a full FIFO stays not-ready even when it pops this cycle.
    assign in_ready  = ~fifo_full & {NPORTS{~rst}};
    assign fifo_push = in_valid & in_ready;

    generate
        for (genvar p = 0; p < NPORTS; p++) begin : g_in
            logic [EW-1:0] wr_w, rd_w;
            assign wr_w = {in_data[p*FLIT_WIDTH +: FLIT_WIDTH], in_last[p],
                           in_dest[p*DW +: DW]};
            router_in_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .push_i  (fifo_push[p]),
                .data_i  (wr_w),
                .pop_i   (fifo_pop[p]),
                .data_o  (rd_w),
                .full_o  (fifo_full[p]),
                .empty_o (fifo_empty[p])
            );
            assign head_w[p] = flit_entry_t'(rd_w);
        end
    endgenerate

    // X is resolved before Y; dest is packed {y, x}.
    function automatic dir_t xy_route(input logic [DW-1:0] dest);
        logic [XW-1:0] dx;
        logic [YW-1:0] dy;
        dx = dest[XW-1:0];
        dy = dest[DW-1:XW];
        if (dx > MY_XC)      return DIR_E;
        else if (dx < MY_XC) return DIR_W;
        else if (dy > MY_YC) return DIR_N;
        else if (dy < MY_YC) return DIR_S;
        else                 return DIR_L;
    endfunction

    // Arbitration. A head flit is whatever sits at the FIFO head while no
    // packet body is in flight on that input; body flits reuse the held route.
    always_comb begin
        idx      = 0;
        fifo_pop = '0;
        for (int p = 0; p < NPORTS; p++) begin
            route_cur[p] = route_vld_q[p] ? route_q[p] : xy_route(head_w[p].dest);
        end
        for (int o = 0; o < NPORTS; o++) begin
            lock_d[o]  = lock_q[o];
            owner_d[o] = owner_q[o];
            rr_d[o]    = rr_q[o];
            gnt_vld[o] = 1'b0;
            gnt_idx[o] = '0;
            for (int p = 0; p < NPORTS; p++) begin
                req_m[o][p] = !fifo_empty[p] && (route_cur[p] == 3'(o));
            end
            if (lock_q[o] == ARB_LOCKED) begin
                gnt_vld[o] = req_m[o][owner_q[o]];
                gnt_idx[o] = owner_q[o];
            end else begin
                for (int k = 0; k < NPORTS; k++) begin
                    idx = int'(rr_q[o]) + k;
                    if (idx >= NPORTS) idx = idx - NPORTS;
                    if (!gnt_vld[o] && req_m[o][idx]) begin
                        gnt_vld[o] = 1'b1;
                        gnt_idx[o] = 3'(idx);
                    end
                end
            end
            xfer[o] = gnt_vld[o] && (!out_valid_q[o] || out_ready[o]);
            if (xfer[o]) begin
                if (head_w[gnt_idx[o]].last) begin
                    lock_d[o] = ARB_UNLOCKED;
                    rr_d[o]   = (gnt_idx[o] == 3'(NPORTS-1)) ? 3'd0 : gnt_idx[o] + 3'd1;
                end else begin
                    lock_d[o]  = ARB_LOCKED;
                    owner_d[o] = gnt_idx[o];
                end
            end
        end
        for (int o = 0; o < NPORTS; o++) begin
            for (int p = 0; p < NPORTS; p++) begin
                if (xfer[o] && gnt_idx[o] == 3'(p)) fifo_pop[p] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= '0;
            route_vld_q <= '0;
            for (int o = 0; o < NPORTS; o++) begin
                lock_q[o]     <= ARB_UNLOCKED;
                owner_q[o]    <= '0;
                rr_q[o]       <= '0;
                out_data_q[o] <= '0;
                out_last_q[o] <= 1'b0;
                out_dest_q[o] <= '0;
                route_q[o]    <= DIR_L;
            end
        end else begin
            for (int o = 0; o < NPORTS; o++) begin
                lock_q[o]  <= lock_d[o];
                owner_q[o] <= owner_d[o];
                rr_q[o]    <= rr_d[o];
                if (xfer[o]) begin
                    out_valid_q[o] <= 1'b1;
                    out_data_q[o]  <= head_w[gnt_idx[o]].data;
                    out_last_q[o]  <= head_w[gnt_idx[o]].last;
                    out_dest_q[o]  <= head_w[gnt_idx[o]].dest;
                end else if (out_ready[o]) begin
                    out_valid_q[o] <= 1'b0;
                end
            end
            for (int p = 0; p < NPORTS; p++) begin
                if (fifo_pop[p]) begin
                    route_q[p]     <= route_cur[p];
                    route_vld_q[p] <= !head_w[p].last;
                end
            end
        end
    end

    assign out_valid = out_valid_q;

    generate
        for (genvar o = 0; o < NPORTS; o++) begin : g_out
            assign out_data[o*FLIT_WIDTH +: FLIT_WIDTH] = out_data_q[o];
            assign out_last[o]                          = out_last_q[o];
            assign out_dest[o*DW +: DW]                 = out_dest_q[o];
        end
    endgenerate

`ifdef MESH_ROUTER_STATS_EN
    logic [31:0] stat_q [NPORTS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int o = 0; o < NPORTS; o++) stat_q[o] <= '0;
        end else begin
            for (int o = 0; o < NPORTS; o++) begin
                if (out_valid_q[o] && out_ready[o]) stat_q[o] <= stat_q[o] + 32'd1;
            end
        end
    end

    generate
        for (genvar o = 0; o < NPORTS; o++) begin : g_stat
            assign stat_flits[o*32 +: 32] = stat_q[o];
        end
    endgenerate
`else
    assign stat_flits = '0;
`endif

endmodule : mesh_xy_router
`default_nettype wire

// File: tb/tb_mesh_xy_router.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_mesh_xy_router
// Purpose : Directed self-checking bench for mesh_xy_router at tile (1,1).
// Revision: 1.0 - initial release
// ============================================================================
module tb_mesh_xy_router;
    localparam int FW = 64;
    localparam int DW = 4;
    localparam int NP = 5;

    typedef struct packed {
        logic [FW-1:0] data;
        logic          last;
        logic [DW-1:0] dest;
        logic [31:0]   cyc;
    } mon_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NP-1:0]   in_valid, in_ready, in_last, out_valid, out_ready, out_last;
    logic [NP*FW-1:0] in_data, out_data;
    logic [NP*DW-1:0] in_dest, out_dest;
    logic [NP*32-1:0] stat_flits;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] cyc      = 0;
    mon_t        mon_q [NP][$];
    mon_t        mon_ent;

    mesh_xy_router #(
        .FLIT_WIDTH(FW), .FIFO_DEPTH(4), .XW(2), .YW(2), .MY_X(1), .MY_Y(1)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_dest(in_dest),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_dest(out_dest), .stat_flits(stat_flits)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every output handshake with the cycle it happens in.
    always @(negedge clk) begin
        for (int o = 0; o < NP; o++) begin
            if (!rst && out_valid[o] && out_ready[o]) begin
                mon_ent.data = out_data[o*FW +: FW];
                mon_ent.last = out_last[o];
                mon_ent.dest = out_dest[o*DW +: DW];
                mon_ent.cyc  = cyc;
                mon_q[o].push_back(mon_ent);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = '0; in_last = '0; in_data = '0; in_dest = '0;
    endtask

    task automatic drive(input int p, input logic [FW-1:0] d, input logic [1:0] x,
                         input logic [1:0] y, input logic l);
        in_valid[p]          = 1'b1;
        in_data[p*FW +: FW]  = d;
        in_last[p]           = l;
        in_dest[p*DW +: DW]  = {y, x};
    endtask

    task automatic clear_mon();
        for (int o = 0; o < NP; o++) mon_q[o].delete();
    endtask

    task automatic do_reset();
        idle_inputs();
        out_ready = '1;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_mon(input int o, input int n, input int budget, output bit ok);
        int c;
        c = 0;
        while (mon_q[o].size() < n && c < budget) begin
            tick();
            c++;
        end
        ok = (mon_q[o].size() >= n);
    endtask

    task automatic test_reset();
        idle_inputs();
        out_ready = '1;
        rst = 1'b1;
        tick();
        n_checks++;
        if (in_ready !== 5'h00) begin n_fail++; $display("FAIL reset_in_ready: got %h need 00", in_ready); end
        n_checks++;
        if (out_valid !== 5'h00) begin n_fail++; $display("FAIL reset_out_valid: got %h need 00", out_valid); end
        n_checks++;
        if (out_data !== '0 || out_last !== '0 || out_dest !== '0) begin
            n_fail++; $display("FAIL reset_out_fields: data %h last %h dest %h need 0", out_data, out_last, out_dest);
        end
        n_checks++;
        if (stat_flits !== '0) begin n_fail++; $display("FAIL reset_stats: got %h need 0", stat_flits); end
        tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if (in_ready !== 5'h1f) begin n_fail++; $display("FAIL post_reset_in_ready: got %h need 1f", in_ready); end
    endtask

    task automatic test_single();
        bit ok;
        clear_mon();
        drive(0, 64'hA5, 2'd3, 2'd1, 1'b1);
        tick();
        idle_inputs();
        n_checks++;
        if (out_valid !== 5'h00) begin n_fail++; $display("FAIL single_cycle1_valid: got %h need 00", out_valid); end
        tick();
        n_checks++;
        if (out_valid !== 5'b00100) begin n_fail++; $display("FAIL single_cycle2_valid: got %b need 00100", out_valid); end
        n_checks++;
        if (out_data[2*FW +: FW] !== 64'hA5 || out_last[2] !== 1'b1 || out_dest[2*DW +: DW] !== 4'b0111) begin
            n_fail++;
            $display("FAIL single_fields: data %h last %b dest %b need a5 1 0111",
                     out_data[2*FW +: FW], out_last[2], out_dest[2*DW +: DW]);
        end
        wait_mon(2, 1, 4, ok);
        tick(); tick();
        n_checks++;
        if (mon_q[0].size() + mon_q[1].size() + mon_q[3].size() + mon_q[4].size() != 0 || mon_q[2].size() != 1) begin
            n_fail++; $display("FAIL single_others_idle: E count %0d others nonzero", mon_q[2].size());
        end
    endtask

    task automatic test_route_sweep();
        logic [1:0] xs [4];
        logic [1:0] ys [4];
        logic [4:0] exp_v [4];
        xs = '{2'd1, 2'd1, 2'd0, 2'd2};
        ys = '{2'd1, 2'd0, 2'd3, 2'd0};
        exp_v = '{5'b00001, 5'b01000, 5'b10000, 5'b00100};
        for (int i = 0; i < 4; i++) begin
            drive(0, 64'h300 + 64'(i), xs[i], ys[i], 1'b1);
            tick();
            idle_inputs();
            tick();
            n_checks++;
            if (out_valid !== exp_v[i]) begin
                n_fail++; $display("FAIL route_sweep_%0d: out_valid %b need %b", i, out_valid, exp_v[i]);
            end
            tick();
        end
    endtask

    task automatic test_arbitration();
        bit ok;
        logic [31:0] c0;
        logic [FW-1:0] ed;
        do_reset();
        clear_mon();
        c0 = cyc;
        for (int k = 0; k < 3; k++) begin
            drive(1, 64'h100 + 64'(k), 2'd1, 2'd1, k == 2);
            drive(4, 64'h400 + 64'(k), 2'd1, 2'd1, k == 2);
            tick();
        end
        idle_inputs();
        wait_mon(0, 6, 30, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL arb_count: got %0d flits need 6", mon_q[0].size()); end
        else begin
            for (int i = 0; i < 6; i++) begin
                ed = (i < 3) ? 64'h100 + 64'(i) : 64'h400 + 64'(i - 3);
                n_checks++;
                if (mon_q[0][i].data !== ed || mon_q[0][i].last !== (i == 2 || i == 5) || mon_q[0][i].cyc !== c0 + 2 + 32'(i)) begin
                    n_fail++;
                    $display("FAIL arb_flit_%0d: data %h last %b cyc %0d need %h %b %0d", i, mon_q[0][i].data,
                             mon_q[0][i].last, mon_q[0][i].cyc, ed, (i == 2 || i == 5), c0 + 2 + 32'(i));
                end
            end
        end
        // N alone moves the pointer past N; then a tie between N and W goes to W.
        clear_mon();
        drive(1, 64'h1AA, 2'd1, 2'd1, 1'b1);
        tick();
        idle_inputs();
        wait_mon(0, 1, 10, ok);
        clear_mon();
        drive(1, 64'h1BB, 2'd1, 2'd1, 1'b1);
        drive(4, 64'h4BB, 2'd1, 2'd1, 1'b1);
        tick();
        idle_inputs();
        wait_mon(0, 2, 10, ok);
        n_checks++;
        if (!ok || mon_q[0][0].data !== 64'h4BB || mon_q[0][1].data !== 64'h1BB) begin
            n_fail++; $display("FAIL arb_rr_order: got %0d flits, first %h need 4bb then 1bb",
                               mon_q[0].size(), ok ? mon_q[0][0].data : 64'h0);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int k, budget;
        logic r;
        clear_mon();
        out_ready[2] = 1'b0;
        k = 0;
        for (int c = 0; c < 12; c++) begin
            drive(0, 64'h700 + 64'(k), 2'd2, 2'd2, k == 9);
            r = in_ready[0];
            tick();
            if (r) k++;
        end
        n_checks++;
        if (k != 5) begin n_fail++; $display("FAIL bp_accepted: got %0d need 5", k); end
        n_checks++;
        if (in_ready[0] !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low: got %b need 0", in_ready[0]); end
        out_ready[2] = 1'b1;
        budget = 0;
        while (k < 10 && budget < 40) begin
            drive(0, 64'h700 + 64'(k), 2'd2, 2'd2, k == 9);
            r = in_ready[0];
            tick();
            if (r) k++;
            budget++;
        end
        idle_inputs();
        wait_mon(2, 10, 40, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL bp_count: got %0d flits need 10", mon_q[2].size()); end
        else begin
            for (int i = 0; i < 10; i++) begin
                n_checks++;
                if (mon_q[2][i].data !== 64'h700 + 64'(i) || mon_q[2][i].last !== (i == 9)) begin
                    n_fail++; $display("FAIL bp_flit_%0d: data %h last %b need %h %b", i,
                                       mon_q[2][i].data, mon_q[2][i].last, 64'h700 + 64'(i), (i == 9));
                end
            end
        end
    endtask

    task automatic test_parallel();
        drive(1, 64'h11, 2'd1, 2'd0, 1'b1);   // N -> S
        drive(2, 64'h22, 2'd3, 2'd1, 1'b1);   // E -> E (U-turn)
        drive(4, 64'h44, 2'd1, 2'd1, 1'b1);   // W -> L
        tick();
        idle_inputs();
        tick();
        n_checks++;
        if (out_valid !== 5'b01101) begin n_fail++; $display("FAIL par_valid: got %b need 01101", out_valid); end
        n_checks++;
        if (out_data[3*FW +: FW] !== 64'h11 || out_data[2*FW +: FW] !== 64'h22 || out_data[0 +: FW] !== 64'h44) begin
            n_fail++; $display("FAIL par_data: S %h E %h L %h need 11 22 44",
                               out_data[3*FW +: FW], out_data[2*FW +: FW], out_data[0 +: FW]);
        end
        tick();
    endtask

    task automatic test_reset_midpacket();
        for (int k = 0; k < 2; k++) begin
            drive(0, 64'h500 + 64'(k), 2'd3, 2'd0, 1'b0);
            tick();
        end
        drive(0, 64'h502, 2'd3, 2'd0, 1'b0);
        rst = 1'b1;
        #1;
        clear_mon();
        n_checks++;
        if (out_valid !== 5'h00 || in_ready !== 5'h00) begin
            n_fail++; $display("FAIL midrst_during: out_valid %h in_ready %h need 00 00", out_valid, in_ready);
        end
        tick();
        rst = 1'b0;
        idle_inputs();
        tick(); tick(); tick(); tick();
        n_checks++;
        if (mon_q[2].size() != 0 || out_valid !== 5'h00 || in_ready !== 5'h1f) begin
            n_fail++; $display("FAIL midrst_flushed: E flits %0d out_valid %h in_ready %h need 0 00 1f",
                               mon_q[2].size(), out_valid, in_ready);
        end
        drive(0, 64'h5A, 2'd1, 2'd3, 1'b1);   // fresh head to N
        tick();
        idle_inputs();
        tick();
        n_checks++;
        if (out_valid !== 5'b00010 || out_data[1*FW +: FW] !== 64'h5A) begin
            n_fail++; $display("FAIL midrst_fresh_head: out_valid %b data %h need 00010 5a",
                               out_valid, out_data[1*FW +: FW]);
        end
        tick(); tick();
    endtask

    task automatic test_stats();
        bit ok;
        logic [31:0] exp_e;
        do_reset();
        clear_mon();
        for (int k = 0; k < 7; k++) begin
            drive(0, 64'h900 + 64'(k), 2'd3, 2'd1, 1'b1);
            tick();
        end
        idle_inputs();
        wait_mon(2, 7, 20, ok);
        tick(); tick();
        n_checks++;
        if (mon_q[2].size() != 7) begin n_fail++; $display("FAIL stats_flits_out: got %0d need 7", mon_q[2].size()); end
`ifdef MESH_ROUTER_STATS_EN
        exp_e = 32'd7;
`else
        exp_e = 32'd0;
`endif
        n_checks++;
        if (stat_flits[2*32 +: 32] !== exp_e) begin
            n_fail++; $display("FAIL stats_east: got %0d need %0d", stat_flits[2*32 +: 32], exp_e);
        end
        n_checks++;
        if (stat_flits[0 +: 64] !== '0 || stat_flits[3*32 +: 64] !== '0) begin
            n_fail++; $display("FAIL stats_others: got %h need 0", stat_flits);
        end
    endtask

    initial begin
        idle_inputs();
        out_ready = '1;
        test_reset();
        test_single();
        test_route_sweep();
        test_arbitration();
        test_backpressure();
        test_parallel();
        test_reset_midpacket();
        test_stats();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mesh_xy_router
`default_nettype wire
